irq_pending_sequencer: RTL
==========================

Name: irq_pending_sequencer

Overview:
- Downstream consumer of the 8:3 priority-encoding scheme, with bit 7 as the highest priority.
- Captures rising edges on 8 request lines into a pending register and applies a mask.
- Selects the highest-priority unmasked pending request and presents its 3-bit code on a valid/ready handshake.
- Clears the serviced pending bit on acceptance. Sits between raw request sources and a single serial service consumer (e.g. an interrupt handler or shared-resource owner).

Parameters:
- N, 8, number of request lines (fixed at 8 for this revision).
- CODE_W, 3, width of the output code, equal to log2(N).
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- req_in, input, 8, level request lines; a 0->1 transition between consecutive samples is one event.
- mask, input, 8, per-line mask; 1 = line not eligible for selection. Masked lines still capture into pending.
- out_code, output, 3, index of the granted line (7 = highest).
- out_valid, output, 1, out_code is valid and held stable.
- out_ready, input, 1, consumer accepts out_code when high together with out_valid at a clk edge.
- pending, output, 8, current pending register.
- drop_cnt, output, 8, count of edges lost because the line was already pending; saturates at 255.

Behaviour:
- Reset (rst=1 at a clk edge):
  - req_d=0, pending=0, out_valid=0, out_code=0, drop_cnt=0, state=IDLE.
  - Reset mid-handshake discards the presented code and all pending events.
  - The first cycle after reset treats any req_in bit already high as a rising edge, because req_d=0.
- Edge capture, at each edge:
  - rise = req_in & ~req_d; then req_d <= req_in.
  - pending[i] <= 1 for every rise[i].
- Drop counting:
  - If rise[i]=1 and pending[i] is already 1 and is not cleared this cycle, the event is dropped; drop_cnt increments once per dropped bit.
  - Several dropped bits in one cycle add their count, saturating at 255.
- Eligibility: elig = pending & ~mask, using registered pending (not including this cycle's rises).
- Selection: code = index of the most significant 1 in elig; combinational, priority 7 > 6 > ... > 0.
- FSM state IDLE:
  - out_valid=0.
  - If elig != 0: out_code <= code, out_valid <= 1, go to PRESENT.
  - Otherwise stay in IDLE.
- FSM state PRESENT:
  - out_valid=1; out_code held stable regardless of new higher-priority arrivals or mask changes. There is no retraction.
  - On out_valid && out_ready: pending[out_code] <= 0, out_valid <= 0, go to IDLE.
  - Otherwise hold.
- Gap between grants: there is a minimum of one idle cycle, since out_valid deasserts for at least one cycle between grants.
- Simultaneous clear and set on the same bit: set wins. A new rise on the line being accepted re-pends it and is not counted as dropped.
- Latency:
  - req_in rising is sampled at edge k, so pending is set after edge k.
  - out_valid is asserted after edge k+1 if the FSM is in IDLE.
- Masking a pending line leaves it pending. Unmasking makes it eligible at the next IDLE evaluation.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset then single event:
  - rst=1 for 2 cycles; req_in=8'b0000_0100 from cycle 3.
  - Required: pending=8'h04 after edge 3; out_valid=1, out_code=2 after edge 4.
  - With out_ready=1: pending=0 and out_valid=0 after edge 5.
- Priority order:
  - req_in 8'h00 -> 8'b0110_0100 in one cycle, out_ready=1 throughout.
  - Required: grants in order 6, 5, 2, each separated by one out_valid=0 cycle; then pending=0.
- Mask and hold:
  - mask=8'h80, req_in rises to 8'h81.
  - Required: code 0 granted, pending=8'h80 retained.
  - Then mask=0: code 7 is granted next.
  - Also: with out_ready=0 in PRESENT, a new rise on bit 7 does not change out_code.
- Drop counting and saturation:
  - Bit 3 is pending and masked; pulse req_in[3] 0->1->0 300 times.
  - Required: drop_cnt=255 and stays at 255.
  - Two bits dropped in the same cycle add 2.
- Set-wins collision:
  - In PRESENT with out_code=4, drive out_ready=1 and a rise on req_in[4] at the same edge.
  - Required: pending[4]=1 afterwards, drop_cnt unchanged, code 4 re-presented.
- Reset mid-operation:
  - rst=1 while out_valid=1 and pending=8'hFF.
  - Required next cycle: out_valid=0, pending=0, drop_cnt=0.
  - Required after release: if req_in is still 8'hFF, all bits re-pend.

Source files
------------

// File: rtl/irq_pending_sequencer.sv
// Edge-capturing interrupt pending register with priority selection (bit 7 highest)
// and a valid/ready grant port that clears the serviced line on acceptance.
module irq_pending_sequencer #(
  parameter int N      = 8,
  parameter int CODE_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_in,
  input  logic [N-1:0]      mask,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      pending,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic {IDLE, PRESENT} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [N-1:0]      req_d;
  logic [N-1:0]      rise;
  logic [N-1:0]      elig;
  logic [N-1:0]      clr;
  logic [N-1:0]      drop_bits;
  logic [N-1:0]      pending_nxt;
  logic [CODE_W-1:0] sel_code;
  logic              accept;

  function automatic logic [CODE_W-1:0] msb_index(input logic [N-1:0] v);
    msb_index = '0;
    for (int i = 0; i < N; i++)
      if (v[i]) msb_index = CODE_W'(i);
  endfunction

  function automatic logic [CODE_W:0] popcount(input logic [N-1:0] v);
    popcount = '0;
    for (int i = 0; i < N; i++)
      popcount = popcount + (CODE_W+1)'(v[i]);
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CODE_W:0]  b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    sat_add = s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign accept      = out_valid & out_ready;
  assign rise        = req_in & ~req_d;
  assign clr         = accept ? ({{(N-1){1'b0}}, 1'b1} << out_code) : '0;
  // A rise on the line being cleared re-pends it rather than counting as a drop.
  assign drop_bits   = rise & pending & ~clr;
  assign pending_nxt = (pending & ~clr) | rise;
  assign elig        = pending & ~mask;
  assign sel_code    = msb_index(elig);

  always_ff @(posedge clk) begin
    if (rst) begin
      req_d    <= '0;
      pending  <= '0;
      drop_cnt <= '0;
    end else begin
      req_d    <= req_in;
      pending  <= pending_nxt;
      drop_cnt <= sat_add(drop_cnt, popcount(drop_bits));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      out_code <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && elig != '0)
        out_code <= sel_code;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (elig != '0) state_nxt = PRESENT;
      PRESENT: if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = (state == PRESENT);
  end

endmodule
